// File: rtl/wb_master_ctrl.sv
// wb_master_ctrl: Wishbone classic single-cycle initiator.
// Takes one read/write command on a valid/ready port and runs exactly one
// Wishbone cycle. Read data or an error status is returned on a
// valid/ready response port. Only one transaction is in flight at a time.
//
// Optional feature macro: WBM_TIMEOUT_EN
//   defined   : a BUS cycle with no ack/err is aborted after TIMEOUT_CYCLES
//               cycles with rsp_err_o=1 and rsp_dat_o=32'hFFFF_FFFF
//   undefined : no timeout counter; the bus cycle waits indefinitely
//
// Ports:
//   wb_clk_i, wb_rst_n_i             clock, async active-low reset
//   cmd_valid_i/cmd_ready_o          command handshake
//   cmd_we_i/adr_i/dat_i/sel_i       command fields
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_dat_o, rsp_err_o             response fields
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   registered Wishbone outputs
//   wbm_dat_i, wbm_ack_i, wbm_err_i  Wishbone slave returns
//   busy_o                           FSM not idle
//
// state  | meaning
// S_IDLE | ready for a command
// S_BUS  | Wishbone cycle in progress (cyc/stb high)
// S_RESP | response held until rsp_ready_i

module wb_master_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 ||
      (64'(1) << TO_W) <= 64'(TIMEOUT_CYCLES)) begin : g_param_chk
    $error("wb_master_ctrl: illegal TIMEOUT_CYCLES/TO_W combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_rsp_dat, w_rsp_dat;
  logic        r_rsp_err, w_rsp_err;
  logic        w_to_exp;

`ifdef WBM_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside BUS, so it always starts from zero on entry.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)           r_to_cnt <= '0;
    else if (r_state != S_BUS) r_to_cnt <= '0;
    else                       r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Count k during the (k+1)th BUS cycle: expiry on the edge ending
  // the TIMEOUT_CYCLES-th cycle with cyc high.
  assign w_to_exp = (r_state == S_BUS) && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_to_exp = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_dat   = r_rsp_dat;
    w_rsp_err   = r_rsp_err;
    case (r_state)
      S_IDLE: if (cmd_valid_i) w_state_nxt = S_BUS;
      S_BUS: begin
        // err beats ack; a real termination beats a coincident timeout
        if (wbm_err_i) begin
          w_state_nxt = S_RESP;
          w_rsp_dat   = '0;
          w_rsp_err   = 1'b1;
        end else if (wbm_ack_i) begin
          w_state_nxt = S_RESP;
          w_rsp_dat   = r_we ? '0 : wbm_dat_i;
          w_rsp_err   = 1'b0;
        end else if (w_to_exp) begin
          w_state_nxt = S_RESP;
          w_rsp_dat   = 32'hFFFF_FFFF;
          w_rsp_err   = 1'b1;
        end
      end
      S_RESP:  if (rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_rsp_dat <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_rsp_dat <= w_rsp_dat;
      r_rsp_err <= w_rsp_err;
      if (r_state == S_IDLE && cmd_valid_i) begin
        r_we   <= cmd_we_i;
        r_sel  <= cmd_sel_i;
        r_adr  <= cmd_adr_i;
        r_wdat <= cmd_we_i ? cmd_dat_i : '0;
      end
    end
  end

  assign cmd_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign busy_o      = (r_state != S_IDLE);
  assign wbm_cyc_o   = (r_state == S_BUS);
  assign wbm_stb_o   = (r_state == S_BUS);
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_wdat;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_wb_master_ctrl.sv
module tb_wb_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [31:0] cmd_adr_i, cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0] rsp_dat_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_ack_i, wbm_err_i, busy_o;

  wb_master_ctrl #(.TIMEOUT_CYCLES(8), .TO_W(16)) u_dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic err; logic [31:0] dat;} rsp_t;
  rsp_t sb_q[$];
  int   acc_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_rsp    = 0;
  int   cyc_n    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Mid-cycle monitor: accepts are logged, response handshakes pop the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (cmd_valid_i && cmd_ready_o) acc_q.push_back(cyc_n);
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          check_val("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          rsp_t e;
          e = sb_q.pop_front();
          check_val("rsp_dat", rsp_dat_o, e.dat);
          check_val("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
          n_rsp++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int lat, input logic ack,
                         input logic err, input logic [31:0] rdata, input logic exp_err,
                         input logic [31:0] exp_dat, input int hold, input bit hold_valid,
                         input bit no_ack, input int exp_to);
    rsp_t e;
    int   cnt;
    logic [31:0] exp_wdat;
    exp_wdat = we ? dat : 32'd0;
    e.err = exp_err;
    e.dat = exp_dat;
    sb_q.push_back(e);
    cnt = 0;
    while (cmd_ready_o !== 1'b1 && cnt < 50) begin step(); cnt++; end
    check_val("cmd_ready_wait", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_dat_i = dat; cmd_sel_i = sel;
    step();
    cmd_valid_i = 1'b0; cmd_we_i = ~we; cmd_adr_i = $urandom; cmd_dat_i = $urandom;
    cmd_sel_i = 4'($urandom);
    check_val("bus_ctl", {25'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
              {25'd0, 1'b1, 1'b1, we, sel});
    check_val("bus_adr", wbm_adr_o, adr);
    check_val("bus_wdat", wbm_dat_o, exp_wdat);
    check_val("bus_ready_busy", {30'd0, cmd_ready_o, busy_o}, 32'd1);
    if (no_ack) begin
      cnt = 0;
      while (wbm_cyc_o === 1'b1 && cnt < 40) begin cnt++; step(); end
      check_val("to_cycles", cnt, exp_to);
    end else begin
      for (int i = 0; i < lat; i++) begin
        step();
        check_val("hold_ctl", {25'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
                  {25'd0, 1'b1, 1'b1, we, sel});
        check_val("hold_adr", wbm_adr_o, adr);
        check_val("hold_wdat", wbm_dat_o, exp_wdat);
      end
      wbm_ack_i = ack; wbm_err_i = err; wbm_dat_i = rdata;
      step();
      wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_dat_i = $urandom;
    end
    check_val("end_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
    check_val("rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    for (int i = 0; i < hold; i++) begin
      if (hold_valid) begin
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0010;
        cmd_dat_i = 32'h0000_0055; cmd_sel_i = 4'h3;
      end
      wbm_dat_i = $urandom;
      step();
      check_val("bp_state", {28'd0, rsp_valid_o, cmd_ready_o, wbm_cyc_o, rsp_err_o},
                {28'd0, 1'b1, 1'b0, 1'b0, exp_err});
      check_val("bp_dat", rsp_dat_o, exp_dat);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check_val("rsp_done", {30'd0, rsp_valid_o, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rsp_before;
    rst_n = 1'b0;
    cmd_valid_i = 0; cmd_we_i = 0; cmd_adr_i = 0; cmd_dat_i = 0; cmd_sel_i = 0;
    rsp_ready_i = 0; wbm_dat_i = 0; wbm_ack_i = 0; wbm_err_i = 0;
    #1;
    check_val("rst_ctl", {27'd0, cmd_ready_o, wbm_cyc_o, wbm_stb_o, rsp_valid_o, busy_o},
              {27'd0, 5'b10000});
    check_val("rst_rsp", {rsp_err_o, rsp_dat_o[30:0]}, 32'd0);
    check_val("rst_bus", wbm_adr_o | wbm_dat_o | {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // write, ack two cycles after stb
    run_txn(1'b1, 32'h3000_0000, 32'h0000_1234, 4'hF, 2, 1'b1, 1'b0, 32'h1111_1111,
            1'b0, 32'd0, 0, 1'b0, 1'b0, 0);
    // read
    run_txn(1'b0, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 1, 1'b1, 1'b0, 32'h0000_ABCD,
            1'b0, 32'h0000_ABCD, 0, 1'b0, 1'b0, 0);
    // read with partial select, immediate ack
    run_txn(1'b0, 32'h3000_0008, 32'h0, 4'h6, 0, 1'b1, 1'b0, 32'h89AB_CDEF,
            1'b0, 32'h89AB_CDEF, 0, 1'b0, 1'b0, 0);
    // bus error, then ack+err together
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1, 1'b0, 1'b1, 32'hDEAD_BEEF,
            1'b1, 32'd0, 0, 1'b0, 1'b0, 0);
    run_txn(1'b0, 32'h3000_000C, 32'h0, 4'hF, 0, 1'b1, 1'b1, 32'h0BAD_F00D,
            1'b1, 32'd0, 0, 1'b0, 1'b0, 0);

    // spurious ack in IDLE
    wbm_ack_i = 1'b1; wbm_dat_i = 32'h1234_5678;
    step();
    wbm_ack_i = 1'b0;
    check_val("spur_ack", {29'd0, busy_o, rsp_valid_o, wbm_cyc_o}, 32'd0);
    step();
    check_val("spur_ack2", {29'd0, busy_o, rsp_valid_o, cmd_ready_o}, 32'd1);

    // backpressure with a command waiting; waiting command then runs
    run_txn(1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 1'b1, 1'b0, 32'h5A5A_0001,
            1'b0, 32'h5A5A_0001, 5, 1'b1, 1'b0, 0);
    run_txn(1'b1, 32'h3000_0010, 32'h0000_0055, 4'h3, 0, 1'b1, 1'b0, 32'h0,
            1'b0, 32'd0, 0, 1'b0, 1'b0, 0);

    // back-to-back spacing with immediate ack and rsp_ready
    acc_q.delete();
    repeat (3) sb_q.push_back(rsp_t'{1'b0, 32'd0});
    cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_adr_i = 32'h3000_0020;
    cmd_dat_i = 32'h0000_0077; cmd_sel_i = 4'hF;
    rsp_ready_i = 1'b1; wbm_ack_i = 1'b1;
    repeat (7) step();
    cmd_valid_i = 1'b0;
    repeat (3) step();
    rsp_ready_i = 1'b0; wbm_ack_i = 1'b0;
    check_val("b2b_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check_val("b2b_gap0", acc_q[1] - acc_q[0], 3);
      check_val("b2b_gap1", acc_q[2] - acc_q[1], 3);
    end

`ifdef WBM_TIMEOUT_EN
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0,
            1'b1, 32'hFFFF_FFFF, 0, 1'b0, 1'b1, 8);
    run_txn(1'b0, 32'h3000_0034, 32'h0, 4'hF, 7, 1'b1, 1'b0, 32'h0000_7777,
            1'b0, 32'h0000_7777, 0, 1'b0, 1'b0, 0);
`else
    run_txn(1'b0, 32'h3000_0030, 32'h0, 4'hF, 20, 1'b1, 1'b0, 32'h0000_4242,
            1'b0, 32'h0000_4242, 0, 1'b0, 1'b0, 0);
`endif

    // reset in the middle of a bus cycle
    n_rsp_before = n_rsp;
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_adr_i = 32'h3000_0040; cmd_sel_i = 4'hF;
    step();
    cmd_valid_i = 1'b0;
    check_val("mid_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async", {29'd0, wbm_cyc_o, wbm_stb_o, rsp_valid_o}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    wbm_ack_i = 1'b1;
    step();
    wbm_ack_i = 1'b0;
    repeat (3) step();
    check_val("rst_after", {29'd0, cmd_ready_o, busy_o, rsp_valid_o}, 32'd4);
    check_val("rst_no_rsp", n_rsp, n_rsp_before);
    check_val("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
